main_mem_arbiter: RTL and testbench

Single-outstanding arbiter that shares the external main-memory port between the I-cache fill path (port 0) and the D-cache MSHR (port 1). It accepts one request at a time through a valid/ready handshake, using round-robin priority. It drives main_mem_req/main_mem_addr until main memory responds, then routes the returned word to the requester that owns the transaction. It also handles pipeline flush of speculative D-side fills and a response timeout.

---
 rtl/main_mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_main_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/main_mem_arbiter.sv
// Round-robin, single-outstanding arbiter sharing the main-memory port
// between the I-cache fill path (port 0) and the D-cache MSHR (port 1).
module main_mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req_valid,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_req_ready,
    output logic              ic_resp_valid,
    output logic [DATA_W-1:0] ic_resp_data,
    input  logic              dc_req_valid,
    input  logic [ADDR_W-1:0] dc_req_addr,
    output logic              dc_req_ready,
    output logic              dc_resp_valid,
    output logic [DATA_W-1:0] dc_resp_data,
    input  logic              flush,
    output logic              main_mem_req,
    output logic [ADDR_W-1:0] main_mem_addr,
    input  logic [DATA_W-1:0] main_mem_data_in,
    input  logic              main_mem_ready,
    output logic              timeout_err
);

    localparam int unsigned TIMER_W = 8;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                owner_q, owner_d;
    logic                drop_q, drop_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                ic_resp_valid_q, ic_resp_valid_d;
    logic [DATA_W-1:0]   ic_resp_data_q, ic_resp_data_d;
    logic                dc_resp_valid_q, dc_resp_valid_d;
    logic [DATA_W-1:0]   dc_resp_data_q, dc_resp_data_d;
    logic                timeout_err_q, timeout_err_d;
    logic                ic_ready_c, dc_ready_c;
    logic                kill_c;

    // Grant decision in IDLE: round-robin on conflict, flush masks the D side.
    always_comb begin
        ic_ready_c = 1'b0;
        dc_ready_c = 1'b0;
        if (rst && (state_q == S_IDLE)) begin
            if (ic_req_valid && dc_req_valid && !flush) begin
                if (last_grant_q) ic_ready_c = 1'b1;
                else              dc_ready_c = 1'b1;
            end else if (ic_req_valid) begin
                ic_ready_c = 1'b1;
            end else if (dc_req_valid && !flush) begin
                dc_ready_c = 1'b1;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        owner_d         = owner_q;
        drop_d          = drop_q;
        timer_d         = timer_q;
        mem_req_d       = mem_req_q;
        mem_addr_d      = mem_addr_q;
        ic_resp_valid_d = 1'b0;
        ic_resp_data_d  = ic_resp_data_q;
        dc_resp_valid_d = 1'b0;
        dc_resp_data_d  = dc_resp_data_q;
        timeout_err_d   = 1'b0;
        kill_c          = drop_q || (flush && owner_q);

        case (state_q)
            S_IDLE: begin
                if (ic_req_valid && ic_ready_c) begin
                    mem_addr_d   = ic_req_addr;
                    owner_d      = 1'b0;
                    last_grant_d = 1'b0;
                    drop_d       = 1'b0;
                    timer_d      = '0;
                    mem_req_d    = 1'b1;
                    state_d      = S_BUSY;
                end else if (dc_req_valid && dc_ready_c) begin
                    mem_addr_d   = dc_req_addr;
                    owner_d      = 1'b1;
                    last_grant_d = 1'b1;
                    drop_d       = 1'b0;
                    timer_d      = '0;
                    mem_req_d    = 1'b1;
                    state_d      = S_BUSY;
                end
            end
            S_BUSY: begin
                timer_d = timer_q + TIMER_W'(1);
                if (flush && owner_q) drop_d = 1'b1;
                if (main_mem_ready) begin
                    if (owner_q) begin
                        dc_resp_data_d  = main_mem_data_in;
                        dc_resp_valid_d = !kill_c;
                    end else begin
                        ic_resp_data_d  = main_mem_data_in;
                        ic_resp_valid_d = 1'b1;
                    end
                    mem_req_d = 1'b0;
                    state_d   = S_RESP;
                end else if (timer_q == TIMER_LAST) begin
                    mem_req_d     = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            last_grant_q    <= 1'b1;
            owner_q         <= 1'b0;
            drop_q          <= 1'b0;
            timer_q         <= '0;
            mem_req_q       <= 1'b0;
            mem_addr_q      <= '0;
            ic_resp_valid_q <= 1'b0;
            ic_resp_data_q  <= '0;
            dc_resp_valid_q <= 1'b0;
            dc_resp_data_q  <= '0;
            timeout_err_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            owner_q         <= owner_d;
            drop_q          <= drop_d;
            timer_q         <= timer_d;
            mem_req_q       <= mem_req_d;
            mem_addr_q      <= mem_addr_d;
            ic_resp_valid_q <= ic_resp_valid_d;
            ic_resp_data_q  <= ic_resp_data_d;
            dc_resp_valid_q <= dc_resp_valid_d;
            dc_resp_data_q  <= dc_resp_data_d;
            timeout_err_q   <= timeout_err_d;
        end
    end

    assign ic_req_ready  = ic_ready_c;
    assign dc_req_ready  = dc_ready_c;
    assign ic_resp_valid = ic_resp_valid_q;
    assign ic_resp_data  = ic_resp_data_q;
    assign dc_resp_valid = dc_resp_valid_q;
    assign dc_resp_data  = dc_resp_data_q;
    assign main_mem_req  = mem_req_q;
    assign main_mem_addr = mem_addr_q;
    assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Directed bench for main_mem_arbiter with a response scoreboard.
module tb_main_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        ic_req_valid;
    logic [31:0] ic_req_addr;
    logic        ic_req_ready;
    logic        ic_resp_valid;
    logic [31:0] ic_resp_data;
    logic        dc_req_valid;
    logic [31:0] dc_req_addr;
    logic        dc_req_ready;
    logic        dc_resp_valid;
    logic [31:0] dc_resp_data;
    logic        flush;
    logic        main_mem_req;
    logic [31:0] main_mem_addr;
    logic [31:0] main_mem_data_in;
    logic        main_mem_ready;
    logic        timeout_err;

    int n_assert = 0;
    int n_fail   = 0;
    logic [32:0] exp_q[$];
    logic [31:0] last_ic;
    logic [31:0] last_dc;

    main_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .ic_req_valid    (ic_req_valid),
        .ic_req_addr     (ic_req_addr),
        .ic_req_ready    (ic_req_ready),
        .ic_resp_valid   (ic_resp_valid),
        .ic_resp_data    (ic_resp_data),
        .dc_req_valid    (dc_req_valid),
        .dc_req_addr     (dc_req_addr),
        .dc_req_ready    (dc_req_ready),
        .dc_resp_valid   (dc_resp_valid),
        .dc_resp_data    (dc_resp_data),
        .flush           (flush),
        .main_mem_req    (main_mem_req),
        .main_mem_addr   (main_mem_addr),
        .main_mem_data_in(main_mem_data_in),
        .main_mem_ready  (main_mem_ready),
        .timeout_err     (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pop the scoreboard whenever a response pulse appears.
    task automatic check_resp(input bit port, input logic vld, input logic [31:0] d);
        logic [32:0] e;
        if (exp_q.size() == 0) begin
            chk(port ? "dc_resp_unexpected" : "ic_resp_unexpected", 32'(vld), 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("resp_port", 32'(port), 32'(e[32]));
            chk("resp_data", d, e[31:0]);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (ic_resp_valid) check_resp(1'b0, ic_resp_valid, ic_resp_data);
            if (dc_resp_valid) check_resp(1'b1, dc_resp_valid, dc_resp_data);
        end
    end

    // One full transaction, entered at a negedge in an IDLE cycle with the
    // requester's valid/addr already driven; returns at the next IDLE negedge.
    task automatic serve(input bit port, input logic [31:0] addr, input logic [31:0] data,
                         input int delay, input bit do_flush, input bit expect_resp,
                         input bit drop_valid, input string tag);
        #1;
        chk({tag, "_ic_ready"}, 32'(ic_req_ready), 32'(port == 1'b0));
        chk({tag, "_dc_ready"}, 32'(dc_req_ready), 32'(port == 1'b1));
        @(negedge clk);
        if (drop_valid) begin
            ic_req_valid = 1'b0;
            dc_req_valid = 1'b0;
        end
        chk({tag, "_mem_req"}, 32'(main_mem_req), 32'd1);
        chk({tag, "_mem_addr"}, main_mem_addr, addr);
        flush = do_flush;
        if (delay > 0) begin
            @(negedge clk);
            flush = 1'b0;
            repeat (delay - 1) @(negedge clk);
            chk({tag, "_addr_hold"}, main_mem_addr, addr);
        end
        main_mem_data_in = data;
        main_mem_ready   = 1'b1;
        if (expect_resp) exp_q.push_back({port, data});
        @(negedge clk);
        main_mem_ready = 1'b0;
        flush          = 1'b0;
        chk({tag, "_resp_valid"}, 32'(port ? dc_resp_valid : ic_resp_valid), 32'(expect_resp));
        chk({tag, "_req_drop"}, 32'(main_mem_req), 32'd0);
        chk({tag, "_no_timeout"}, 32'(timeout_err), 32'd0);
        chk({tag, "_resp_ready"}, 32'({ic_req_ready, dc_req_ready}), 32'd0);
        if (expect_resp) begin
            chk({tag, "_data"}, port ? dc_resp_data : ic_resp_data, data);
            if (port) last_dc = data;
            else      last_ic = data;
        end
        @(negedge clk);
        chk({tag, "_pulse_end"}, 32'(port ? dc_resp_valid : ic_resp_valid), 32'd0);
    endtask

    initial begin
        int cnt;
        rst              = 1'b0;
        ic_req_valid     = 1'b0;
        ic_req_addr      = '0;
        dc_req_valid     = 1'b0;
        dc_req_addr      = '0;
        flush            = 1'b0;
        main_mem_data_in = '0;
        main_mem_ready   = 1'b0;
        last_ic          = '0;
        last_dc          = '0;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_mem_req", 32'(main_mem_req), 32'd0);
        chk("rst_mem_addr", main_mem_addr, 32'd0);
        chk("rst_ic_data", ic_resp_data, 32'd0);
        chk("rst_dc_data", dc_resp_data, 32'd0);
        chk("rst_valids", 32'({ic_resp_valid, dc_resp_valid, timeout_err}), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Simultaneous requests: IC, then DC, then IC again
        ic_req_valid = 1'b1; ic_req_addr = 32'h100;
        dc_req_valid = 1'b1; dc_req_addr = 32'h200;
        serve(1'b0, 32'h100, 32'h0000_1111, 1, 1'b0, 1'b1, 1'b0, "rr_ic1");
        serve(1'b1, 32'h200, 32'h0000_2222, 0, 1'b0, 1'b1, 1'b0, "rr_dc");
        serve(1'b0, 32'h100, 32'h0000_3333, 3, 1'b0, 1'b1, 1'b1, "rr_ic2");

        // IC-only read, memory answers 2 cycles after req rises
        ic_req_valid = 1'b1; ic_req_addr = 32'h0000_1000;
        serve(1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 2, 1'b0, 1'b1, 1'b1, "ic_only");

        // Flush kills a DC fill (flush earlier than response, and coincident)
        dc_req_valid = 1'b1; dc_req_addr = 32'h40;
        serve(1'b1, 32'h40, 32'h0000_1234, 2, 1'b1, 1'b0, 1'b1, "dc_flush");
        dc_req_valid = 1'b1; dc_req_addr = 32'h44;
        serve(1'b1, 32'h44, 32'h0000_5678, 0, 1'b1, 1'b0, 1'b1, "dc_flush0");

        // Flush does not affect an IC fill
        ic_req_valid = 1'b1; ic_req_addr = 32'h50;
        serve(1'b0, 32'h50, 32'hCAFE_0001, 1, 1'b1, 1'b1, 1'b1, "ic_flush");

        // Flush in IDLE masks DC; IC still follows normal rules
        dc_req_valid = 1'b1; dc_req_addr = 32'h80;
        ic_req_valid = 1'b1; ic_req_addr = 32'h90;
        flush        = 1'b1;
        #1;
        chk("flush_idle_ic_ready", 32'(ic_req_ready), 32'd1);
        chk("flush_idle_dc_ready_both", 32'(dc_req_ready), 32'd0);
        ic_req_valid = 1'b0;
        #1;
        chk("flush_idle_dc_ready", 32'(dc_req_ready), 32'd0);
        @(negedge clk);
        chk("flush_idle_no_accept", 32'(main_mem_req), 32'd0);
        flush = 1'b0;
        serve(1'b1, 32'h80, 32'hBEEF_0080, 0, 1'b0, 1'b1, 1'b1, "after_flush");

        // Timeout: memory never answers
        ic_req_valid = 1'b1; ic_req_addr = 32'h300;
        #1;
        chk("to_ic_ready", 32'(ic_req_ready), 32'd1);
        @(negedge clk);
        ic_req_valid = 1'b0;
        cnt = 0;
        while (main_mem_req && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        chk("to_req_cycles", 32'(cnt), 32'd8);
        chk("to_err_pulse", 32'(timeout_err), 32'd1);
        chk("to_no_resp", 32'({ic_resp_valid, dc_resp_valid}), 32'd0);
        main_mem_data_in = 32'h0000_AAAA;
        main_mem_ready   = 1'b1;
        @(negedge clk);
        main_mem_ready = 1'b0;
        chk("to_err_end", 32'(timeout_err), 32'd0);
        chk("late_no_resp", 32'({ic_resp_valid, dc_resp_valid}), 32'd0);
        chk("late_no_req", 32'(main_mem_req), 32'd0);
        @(negedge clk);
        chk("late_ic_data_hold", ic_resp_data, last_ic);
        chk("late_dc_data_hold", dc_resp_data, last_dc);

        // Response on the expiry cycle is a normal completion
        dc_req_valid = 1'b1; dc_req_addr = 32'h400;
        serve(1'b1, 32'h400, 32'h0000_7777, 7, 1'b0, 1'b1, 1'b1, "expiry_win");

        // Async reset mid-BUSY
        ic_req_valid = 1'b1; ic_req_addr = 32'h700;
        #1;
        chk("ar_ic_ready", 32'(ic_req_ready), 32'd1);
        @(negedge clk);
        chk("ar_busy", 32'(main_mem_req), 32'd1);
        dc_req_valid = 1'b1; dc_req_addr = 32'h800;
        #2;
        rst = 1'b0;
        #1;
        chk("ar_mem_req", 32'(main_mem_req), 32'd0);
        chk("ar_mem_addr", main_mem_addr, 32'd0);
        chk("ar_ic_data", ic_resp_data, 32'd0);
        chk("ar_dc_data", dc_resp_data, 32'd0);
        chk("ar_ready", 32'({ic_req_ready, dc_req_ready}), 32'd0);
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
        @(negedge clk);
        rst              = 1'b1;
        main_mem_data_in = 32'h0000_5555;
        main_mem_ready   = 1'b1;
        @(negedge clk);
        main_mem_ready = 1'b0;
        chk("ar_stale_ignored", 32'({ic_resp_valid, dc_resp_valid, main_mem_req}), 32'd0);
        chk("ar_stale_data", ic_resp_data, 32'd0);
        ic_req_valid = 1'b1; ic_req_addr = 32'h100;
        dc_req_valid = 1'b1; dc_req_addr = 32'h200;
        serve(1'b0, 32'h100, 32'h0000_9999, 0, 1'b0, 1'b1, 1'b1, "ar_first_ic");

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
